collision_event_scheduler: RTL

Collects the one-shot collision pulses produced during a video frame, snapshots them at the frame boundary, and issues them one at a time, highest priority first, to the ball-physics controller over a valid/ready handshake. It sits between the collision detector and the ball/score logic. It guarantees a deterministic per-frame order of physics updates and bounds the time spent waiting on a stalled consumer.

---
 rtl/pinball_pkg.sv | 30 +++
 rtl/priority_picker.sv | 23 ++
 rtl/collision_event_scheduler.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pinball_pkg.sv
// Shared pinball types: collision event codes (priority order), scheduler states, mask helpers.
package pinball_pkg;

  localparam int NUM_COLLISION_EVENTS = 7;

  // Lower code means higher service priority; mask bit (code-1) holds that event.
  typedef enum logic [2:0] {
    NONE          = 3'd0,
    BOTTOM        = 3'd1,
    SPRING        = 3'd2,
    FLIPPER       = 3'd3,
    BUMPER        = 3'd4,
    OBSTACLE_BAD  = 3'd5,
    OBSTACLE_GOOD = 3'd6,
    FRAME         = 3'd7
  } collision_event_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_e;

  function automatic logic [3:0] popCount(input logic [NUM_COLLISION_EVENTS-1:0] m);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_COLLISION_EVENTS; i++) n = n + 4'(m[i]);
    return n;
  endfunction

endpackage

// File: rtl/priority_picker.sv
// Combinational priority encoder: lowest set mask bit wins, returns its event code and one-hot clear mask.
// Zero latency, no flow control; an empty mask yields NONE and an all-zero clear mask.
module priority_picker
  import pinball_pkg::*;
(
  input  logic [NUM_COLLISION_EVENTS-1:0] mask,
  output collision_event_e                code,
  output logic [NUM_COLLISION_EVENTS-1:0] clearMask
);

  always_comb begin
    code      = NONE;
    clearMask = '0;
    for (int i = NUM_COLLISION_EVENTS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        code         = collision_event_e'(3'(i + 1));
        clearMask    = '0;
        clearMask[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/collision_event_scheduler.sv
// Per-frame collision snapshot issued highest priority first; snapshot at T gives event_valid at T+1, one event/cycle.
// A stalled consumer drops an event after TIMEOUT_CYCLES; `COLLISION_SCHED_STATS_EN enables dropped_count.
module collision_event_scheduler
  import pinball_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       collisionSmileyFrame,
  input  logic       collisionSmileyFlipper,
  input  logic       collisionSmileyBumper,
  input  logic       collisionSmileySpringPulse,
  input  logic       collisionSmileyBottom,
  input  logic       collisionSmileyObstacleGood,
  input  logic       collisionSmileyObstacleBad,
  output logic       event_valid,
  output logic [2:0] event_code,
  input  logic       event_ready,
  output logic       busy,
  output logic       overrun,
  output logic [7:0] dropped_count
);

  localparam int                CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  sched_state_e                    state;
  logic [NUM_COLLISION_EVENTS-1:0] pulses;
  logic [NUM_COLLISION_EVENTS-1:0] pendingMask;
  logic [NUM_COLLISION_EVENTS-1:0] serviceMask;
  logic [NUM_COLLISION_EVENTS-1:0] curClear;
  logic [NUM_COLLISION_EVENTS-1:0] serviceAfter;
  logic [NUM_COLLISION_EVENTS-1:0] nextService;
  logic [NUM_COLLISION_EVENTS-1:0] nextClear;
  collision_event_e                nextCode;
  logic [CNT_W-1:0]                timeoutCnt;
  logic                            handshake;
  logic                            timeoutHit;
  logic [3:0]                      dropsNow;

  assign pulses = {collisionSmileyFrame, collisionSmileyObstacleGood, collisionSmileyObstacleBad,
                   collisionSmileyBumper, collisionSmileyFlipper, collisionSmileySpringPulse,
                   collisionSmileyBottom};

  assign handshake  = (state == ISSUE) && event_ready;
  assign timeoutHit = (state == ISSUE) && !event_ready && (timeoutCnt == LIMIT);

  // curClear is the registered one-hot of the event currently on event_code.
  always_comb begin
    serviceAfter = serviceMask;
    if (handshake || timeoutHit) serviceAfter = serviceMask & ~curClear;
    nextService = startOfFrame ? pendingMask : serviceAfter;
    dropsNow    = (timeoutHit ? 4'd1 : 4'd0) + (startOfFrame ? popCount(serviceAfter) : 4'd0);
  end

  priority_picker nextPick (
    .mask      (nextService),
    .code      (nextCode),
    .clearMask (nextClear)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pendingMask <= '0;
      serviceMask <= '0;
      curClear    <= '0;
      timeoutCnt  <= '0;
      event_valid <= 1'b0;
      event_code  <= NONE;
      overrun     <= 1'b0;
    end else begin
      pendingMask <= startOfFrame ? pulses : (pendingMask | pulses);
      serviceMask <= nextService;
      curClear    <= nextClear;
      event_valid <= |nextService;
      event_code  <= nextCode;
      if (dropsNow != 4'd0) overrun <= 1'b1;
      case (state)
        IDLE: begin
          timeoutCnt <= '0;
          if (|nextService) state <= ISSUE;
        end
        ISSUE: begin
          if (!(|nextService)) begin
            state      <= IDLE;
            timeoutCnt <= '0;
          end else if (handshake || timeoutHit || startOfFrame) begin
            timeoutCnt <= '0;
          end else begin
            timeoutCnt <= timeoutCnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = |serviceMask;

`ifdef COLLISION_SCHED_STATS_EN
  logic [7:0] dropCnt;
  logic [8:0] dropSum;

  assign dropSum = {1'b0, dropCnt} + {5'b0, dropsNow};

  always_ff @(posedge clk) begin
    if (reset)                 dropCnt <= '0;
    else if (dropSum > 9'd255) dropCnt <= 8'd255;
    else                       dropCnt <= dropSum[7:0];
  end

  assign dropped_count = dropCnt;
`else
  assign dropped_count = '0;
`endif

endmodule
